// File: rtl/datapath_controller.sv
// rtl/datapath_controller.sv - fetch/decode/execute sequencer for the 8-bit accumulator datapath
// Two-process FSM; all control outputs are combinational from state, IReg, Acc and Mem_Ready.
module datapath_controller #(
  parameter bit USE_READY = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       IReg_Data_Out,
  input  logic [7:0]       Acc_Data_Out,
  input  logic             Mem_Ready,
  output logic             IReg_En,
  output logic             PC_En,
  output logic             IAR_En,
  output logic             Acc_En,
  output logic             PC_Buffer_Sel,
  output logic             IReg_Buffer_Sel,
  output logic             IAR_Buffer_Sel,
  output logic             Acc_Buffer_Sel,
  output logic             Mux_PC_Add_Sel,
  output logic             Mux_PC_In_Sel,
  output logic [1:0]       Mux_Acc_In_Sel,
  output logic [1:0]       ALU_Sel,
  output logic             Mem_Rd,
  output logic             Mem_Wr,
  output logic             Halted,
  output logic [CNT_W-1:0] Instr_Count
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_INDIR  = 3'd3,
    S_EXEC2  = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_count;
  logic             w_retire;
  logic             w_ready;
  logic [3:0]       w_op;
  logic             w_is_alu;

  assign w_op     = IReg_Data_Out[7:4];
  assign w_is_alu = (w_op[3:2] == 2'b01);
  assign w_ready  = USE_READY ? Mem_Ready : 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_FETCH;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_count <= r_count + CNT_ONE;
    end
  end

  always_comb begin
    w_next          = r_state;
    w_retire        = 1'b0;
    IReg_En         = 1'b0;
    PC_En           = 1'b0;
    IAR_En          = 1'b0;
    Acc_En          = 1'b0;
    PC_Buffer_Sel   = 1'b0;
    IReg_Buffer_Sel = 1'b0;
    IAR_Buffer_Sel  = 1'b0;
    Acc_Buffer_Sel  = 1'b0;
    Mux_PC_Add_Sel  = 1'b1;
    Mux_PC_In_Sel   = 1'b0;
    Mux_Acc_In_Sel  = 2'b00;
    ALU_Sel         = 2'b00;
    Mem_Rd          = 1'b0;
    Mem_Wr          = 1'b0;
    Halted          = 1'b0;

    case (r_state)
      S_FETCH: begin
        PC_Buffer_Sel = 1'b1;
        Mem_Rd        = 1'b1;
        if (w_ready) begin
          IReg_En = 1'b1;
          PC_En   = 1'b1;
          w_next  = S_DECODE;
        end
      end
      S_DECODE: begin
        case (w_op)
          4'h1: begin
            Acc_En         = 1'b1;
            Mux_Acc_In_Sel = 2'b01;
            w_retire       = 1'b1;
            w_next         = S_FETCH;
          end
          4'hA: begin
            PC_En          = 1'b1;
            Mux_PC_Add_Sel = 1'b0;
            w_retire       = 1'b1;
            w_next         = S_FETCH;
          end
          4'hB: begin
            if (Acc_Data_Out == 8'h00) begin
              PC_En          = 1'b1;
              Mux_PC_Add_Sel = 1'b0;
            end
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end
          4'hF: begin
            w_retire = 1'b1;
            w_next   = S_HALT;
          end
          4'h8, 4'h9: w_next = S_INDIR;
          4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hC: w_next = S_EXEC;
          default: begin
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end
        endcase
      end
      S_EXEC: begin
        IReg_Buffer_Sel = 1'b1;
        if (w_op == 4'h3) begin
          Mem_Wr         = 1'b1;
          Acc_Buffer_Sel = 1'b1;
        end else begin
          Mem_Rd = 1'b1;
        end
        if (w_is_alu) ALU_Sel = w_op[1:0];
        if (w_ready) begin
          if (w_op == 4'h2) begin
            Acc_En         = 1'b1;
            Mux_Acc_In_Sel = 2'b10;
          end else if (w_is_alu) begin
            Acc_En         = 1'b1;
            Mux_Acc_In_Sel = 2'b11;
          end else if (w_op == 4'hC) begin
            PC_En         = 1'b1;
            Mux_PC_In_Sel = 1'b1;
          end
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end
      end
      S_INDIR: begin
        IReg_Buffer_Sel = 1'b1;
        Mem_Rd          = 1'b1;
        if (w_ready) begin
          IAR_En = 1'b1;
          w_next = S_EXEC2;
        end
      end
      S_EXEC2: begin
        IAR_Buffer_Sel = 1'b1;
        if (w_op == 4'h9) begin
          Mem_Wr         = 1'b1;
          Acc_Buffer_Sel = 1'b1;
        end else begin
          Mem_Rd = 1'b1;
        end
        if (w_ready) begin
          if (w_op == 4'h8) begin
            Acc_En         = 1'b1;
            Mux_Acc_In_Sel = 2'b10;
          end
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end
      end
      S_HALT: Halted = 1'b1;
      default: w_next = S_FETCH;
    endcase

    // Reset overrides everything so a half-finished instruction writes nothing.
    if (!rst) begin
      w_next          = S_FETCH;
      w_retire        = 1'b0;
      IReg_En         = 1'b0;
      PC_En           = 1'b0;
      IAR_En          = 1'b0;
      Acc_En          = 1'b0;
      PC_Buffer_Sel   = 1'b0;
      IReg_Buffer_Sel = 1'b0;
      IAR_Buffer_Sel  = 1'b0;
      Acc_Buffer_Sel  = 1'b0;
      Mux_PC_Add_Sel  = 1'b1;
      Mux_PC_In_Sel   = 1'b0;
      Mux_Acc_In_Sel  = 2'b00;
      ALU_Sel         = 2'b00;
      Mem_Rd          = 1'b0;
      Mem_Wr          = 1'b0;
      Halted          = 1'b0;
    end
  end

  assign Instr_Count = rst ? r_count : '0;

endmodule

// File: tb/tb_datapath_controller.sv
// tb/tb_datapath_controller.sv - scoreboard bench for datapath_controller
// Stimulus pushes the expected control word per cycle; a negedge monitor pops and compares.
module tb_datapath_controller;

  logic        clk;
  logic        rst;
  logic [7:0]  IReg_Data_Out;
  logic [7:0]  Acc_Data_Out;
  logic        Mem_Ready;
  logic        IReg_En, PC_En, IAR_En, Acc_En;
  logic        PC_Buffer_Sel, IReg_Buffer_Sel, IAR_Buffer_Sel, Acc_Buffer_Sel;
  logic        Mux_PC_Add_Sel, Mux_PC_In_Sel;
  logic [1:0]  Mux_Acc_In_Sel, ALU_Sel;
  logic        Mem_Rd, Mem_Wr, Halted;
  logic [15:0] Instr_Count;

  datapath_controller #(.USE_READY(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .IReg_Data_Out(IReg_Data_Out), .Acc_Data_Out(Acc_Data_Out), .Mem_Ready(Mem_Ready),
    .IReg_En(IReg_En), .PC_En(PC_En), .IAR_En(IAR_En), .Acc_En(Acc_En),
    .PC_Buffer_Sel(PC_Buffer_Sel), .IReg_Buffer_Sel(IReg_Buffer_Sel),
    .IAR_Buffer_Sel(IAR_Buffer_Sel), .Acc_Buffer_Sel(Acc_Buffer_Sel),
    .Mux_PC_Add_Sel(Mux_PC_Add_Sel), .Mux_PC_In_Sel(Mux_PC_In_Sel),
    .Mux_Acc_In_Sel(Mux_Acc_In_Sel), .ALU_Sel(ALU_Sel),
    .Mem_Rd(Mem_Rd), .Mem_Wr(Mem_Wr), .Halted(Halted), .Instr_Count(Instr_Count)
  );

  localparam logic [16:0] B_IREN  = 17'd1 << 16;
  localparam logic [16:0] B_PCEN  = 17'd1 << 15;
  localparam logic [16:0] B_IAREN = 17'd1 << 14;
  localparam logic [16:0] B_ACCEN = 17'd1 << 13;
  localparam logic [16:0] B_PCB   = 17'd1 << 12;
  localparam logic [16:0] B_IRB   = 17'd1 << 11;
  localparam logic [16:0] B_IARB  = 17'd1 << 10;
  localparam logic [16:0] B_ACCB  = 17'd1 << 9;
  localparam logic [16:0] B_ADD   = 17'd1 << 8;
  localparam logic [16:0] B_PCIN  = 17'd1 << 7;
  localparam logic [16:0] SEL01   = 17'd1 << 5;
  localparam logic [16:0] SEL10   = 17'd2 << 5;
  localparam logic [16:0] SEL11   = 17'd3 << 5;
  localparam logic [16:0] ALU10   = 17'd2 << 3;
  localparam logic [16:0] B_RD    = 17'd1 << 2;
  localparam logic [16:0] B_WR    = 17'd1 << 1;
  localparam logic [16:0] B_HLT   = 17'd1;
  localparam logic [16:0] F_RDY   = B_PCB | B_RD | B_IREN | B_PCEN | B_ADD;

  typedef struct {
    logic [16:0] ctl;
    logic [15:0] cnt;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [16:0] w_ctl;

  assign w_ctl = {IReg_En, PC_En, IAR_En, Acc_En, PC_Buffer_Sel, IReg_Buffer_Sel,
                  IAR_Buffer_Sel, Acc_Buffer_Sel, Mux_PC_Add_Sel, Mux_PC_In_Sel,
                  Mux_Acc_In_Sel, ALU_Sel, Mem_Rd, Mem_Wr, Halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      if (w_ctl !== e.ctl) begin
        n_fail++;
        $display("FAIL %s ctl actual=%05h required=%05h", e.tag, w_ctl, e.ctl);
      end
      n_checks++;
      if (Instr_Count !== e.cnt) begin
        n_fail++;
        $display("FAIL %s count actual=%0d required=%0d", e.tag, Instr_Count, e.cnt);
      end
      n_checks++;
      if ((32'(PC_Buffer_Sel) + 32'(IReg_Buffer_Sel) + 32'(IAR_Buffer_Sel) > 1) || (Mem_Rd && Mem_Wr)) begin
        n_fail++;
        $display("FAIL %s exclusive actual=%05h required=one-hot-sel,no-rd+wr", e.tag, w_ctl);
      end
    end
  end

  task automatic step(input logic rn, input logic [7:0] ir, input logic [7:0] acc,
                      input logic rdy, input logic [16:0] ctl, input logic [15:0] cnt,
                      input string tag);
    exp_t e;
    rst           = rn;
    IReg_Data_Out = ir;
    Acc_Data_Out  = acc;
    Mem_Ready     = rdy;
    e.ctl = ctl;
    e.cnt = cnt;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; IReg_Data_Out = 8'h00; Acc_Data_Out = 8'h00; Mem_Ready = 1'b1;
    @(posedge clk);
    #1;
    step(0, 8'h00, 8'h00, 1, B_ADD, 0, "reset0");
    step(0, 8'h00, 8'h00, 1, B_ADD, 0, "reset1");
    // LDI 3 then HLT
    step(1, 8'h00, 8'h00, 1, F_RDY, 0, "fetch_ldi");
    step(1, 8'h13, 8'h00, 1, B_ADD | B_ACCEN | SEL01, 0, "dec_ldi");
    step(1, 8'h13, 8'h03, 1, F_RDY, 1, "fetch_hlt");
    step(1, 8'hF0, 8'h03, 1, B_ADD, 1, "dec_hlt");
    step(1, 8'hF0, 8'h03, 1, B_ADD | B_HLT, 2, "halt0");
    step(1, 8'hF0, 8'h03, 0, B_ADD | B_HLT, 2, "halt1");
    step(0, 8'hF0, 8'h03, 1, B_ADD, 0, "rst_in_halt");
    // LDA 5 with a fetch wait and two exec waits
    step(1, 8'h00, 8'h00, 0, B_PCB | B_RD | B_ADD, 0, "fetch_wait");
    step(1, 8'h00, 8'h00, 1, F_RDY, 0, "fetch_lda");
    step(1, 8'h25, 8'h00, 1, B_ADD, 0, "dec_lda");
    step(1, 8'h25, 8'h00, 0, B_ADD | B_IRB | B_RD, 0, "exec_lda_w0");
    step(1, 8'h25, 8'h00, 0, B_ADD | B_IRB | B_RD, 0, "exec_lda_w1");
    step(1, 8'h25, 8'h00, 1, B_ADD | B_IRB | B_RD | B_ACCEN | SEL10, 0, "exec_lda");
    // ALU opcode 6
    step(1, 8'h00, 8'h5A, 1, F_RDY, 1, "fetch_alu");
    step(1, 8'h6A, 8'h5A, 1, B_ADD, 1, "dec_alu");
    step(1, 8'h6A, 8'h5A, 1, B_ADD | B_IRB | B_RD | ALU10 | B_ACCEN | SEL11, 1, "exec_alu");
    // LDN 4 with one INDIR wait
    step(1, 8'h00, 8'h00, 1, F_RDY, 2, "fetch_ldn");
    step(1, 8'h84, 8'h00, 1, B_ADD, 2, "dec_ldn");
    step(1, 8'h84, 8'h00, 0, B_ADD | B_IRB | B_RD, 2, "indir_ldn_w");
    step(1, 8'h84, 8'h00, 1, B_ADD | B_IRB | B_RD | B_IAREN, 2, "indir_ldn");
    step(1, 8'h84, 8'h00, 1, B_ADD | B_IARB | B_RD | B_ACCEN | SEL10, 2, "exec2_ldn");
    // BZ taken, BZ not taken, BRA
    step(1, 8'h00, 8'h00, 1, F_RDY, 3, "fetch_bz0");
    step(1, 8'hB3, 8'h00, 1, B_PCEN, 3, "dec_bz_taken");
    step(1, 8'h00, 8'h01, 1, F_RDY, 4, "fetch_bz1");
    step(1, 8'hB3, 8'h01, 1, B_ADD, 4, "dec_bz_not");
    step(1, 8'h00, 8'h01, 1, F_RDY, 5, "fetch_bra");
    step(1, 8'hA5, 8'h01, 1, B_PCEN, 5, "dec_bra");
    // STA 7 with one wait
    step(1, 8'h00, 8'h44, 1, F_RDY, 6, "fetch_sta");
    step(1, 8'h37, 8'h44, 1, B_ADD, 6, "dec_sta");
    step(1, 8'h37, 8'h44, 0, B_ADD | B_IRB | B_WR | B_ACCB, 6, "exec_sta_w");
    step(1, 8'h37, 8'h44, 1, B_ADD | B_IRB | B_WR | B_ACCB, 6, "exec_sta");
    // JMI 2
    step(1, 8'h00, 8'h44, 1, F_RDY, 7, "fetch_jmi");
    step(1, 8'hC2, 8'h44, 1, B_ADD, 7, "dec_jmi");
    step(1, 8'hC2, 8'h44, 1, B_ADD | B_IRB | B_RD | B_PCEN | B_PCIN, 7, "exec_jmi");
    // Reserved opcode D acts as NOP
    step(1, 8'h00, 8'h44, 1, F_RDY, 8, "fetch_rsv");
    step(1, 8'hD4, 8'h44, 1, B_ADD, 8, "dec_rsv");
    // STN complete
    step(1, 8'h00, 8'h44, 1, F_RDY, 9, "fetch_stn");
    step(1, 8'h99, 8'h44, 1, B_ADD, 9, "dec_stn");
    step(1, 8'h99, 8'h44, 1, B_ADD | B_IRB | B_RD | B_IAREN, 9, "indir_stn");
    step(1, 8'h99, 8'h44, 1, B_ADD | B_IARB | B_WR | B_ACCB, 9, "exec2_stn");
    // STN abandoned by reset in EXEC2
    step(1, 8'h00, 8'h44, 1, F_RDY, 10, "fetch_stn2");
    step(1, 8'h99, 8'h44, 1, B_ADD, 10, "dec_stn2");
    step(1, 8'h99, 8'h44, 1, B_ADD | B_IRB | B_RD | B_IAREN, 10, "indir_stn2");
    step(0, 8'h99, 8'h44, 1, B_ADD, 0, "rst_in_exec2");
    step(1, 8'h00, 8'h44, 1, F_RDY, 0, "fetch_after_rst");
    step(1, 8'h00, 8'h44, 1, B_ADD, 0, "dec_nop");
    step(1, 8'h00, 8'h44, 1, F_RDY, 1, "fetch_final");

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain pending actual=%0d required=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
